jtag_dtm_oversampled: RTL and testbench
=======================================

// Module: jtag_dtm_oversampled
// PURPOSE
//  Debug transport module for the non-direct-DMI build: JTAG TAP responder plus RISC-V DTM (debug spec 0.13).
//  Oversamples the JTAG pins on the system clock, decodes TAP/IR/DR, and issues DMI requests to rv_dm.
//  Sits between the SoC JTAG pins (driven by jtagdpi/OpenOCD in simulation) and the debug module.
// PARAMETERS
//  IdcodeValue  32'h0000_0001  value shifted out of IDCODE (bit 0 must be 1)
//  AddrWidth    7              DMI address bits (abits)
//  IdleCycles   3'd1           DTMCS.idle hint
// PORTS
//  clock            in   1   system clock; the only clock
//  reset_ni         in   1   asynchronous active-low reset
//  jtag_tck_i       in   1   JTAG TCK, asynchronous, sampled on clock
//  jtag_tms_i       in   1   JTAG TMS
//  jtag_tdi_i       in   1   JTAG TDI
//  jtag_trst_ni     in   1   JTAG TRST, active-low, synchronised then applied
//  jtag_tdo_o       out  1   JTAG TDO
//  jtag_tdo_oe_o    out  1   TDO drive enable (Shift-IR/Shift-DR only)
//  dmi_req_valid_o  out  1   DMI request valid
//  dmi_req_ready_i  in   1   DMI request accepted
//  dmi_req_addr_o   out  AddrWidth  DMI address
//  dmi_req_op_o     out  2   1=read, 2=write
//  dmi_req_data_o   out  32  DMI write data
//  dmi_rsp_valid_i  in   1   DMI response valid
//  dmi_rsp_ready_o  out  1   DMI response ready
//  dmi_rsp_data_i   in   32  DMI read data
//  dmi_rsp_resp_i   in   2   0=ok, else failed
//  dmi_rst_no       out  1   DMI reset to rv_dm, active-low
// BEHAVIOUR
//  - Reset (reset_ni low): TAP=TestLogicReset, IR=IDCODE(5'h01), all outputs 0 except dmi_rst_no=1; dmistat=0.
//  - Pin sync: 2-flop synchronisers on tck/tms/tdi/trst_n; tck rise/fall detected from sync'd stages.
//    Requirement on TCK: high and low phases each >= 2 clock periods; faster TCK is unsupported.
//  - Rising TCK edge: advance 16-state IEEE 1149.1 TAP on TMS; in Shift-IR/DR shift TDI in at MSB, LSB out.
//  - Falling TCK edge: register TDO/TDO_OE from shift LSB; pin update <= 3 clocks after falling edge at pin.
//  - Sync'd trst low: TAP to TestLogicReset, IR=IDCODE next clock; DMI handshake untouched.
//  - TMS high for 5 TCK rises from any state -> TestLogicReset.
//  - IR 5 bits; Capture-IR loads 5'b00001. IR codes: 01 IDCODE, 10 DTMCS, 11 DMI, 1F BYPASS; others BYPASS.
//  - DTMCS (32b): [3:0]=1, [9:4]=AddrWidth, [11:10]=dmistat, [14:12]=IdleCycles; Update-DR
//    bit16=dmireset clears dmistat; bit17=dmihardreset drops dmi_rst_no for 1 clock, aborts pending op.
//  - DMI DR (AddrWidth+34 b) = {addr,data,op}. Capture-DR: {last_addr,last_rdata,status} where
//    status = dmistat if nonzero, 3 if an op is still outstanding, else 0.
//  - Update-DR on DMI, op in {1,2}: if outstanding -> dmistat=3 (sticky), request dropped;
//    else if dmistat!=0 -> dropped; else latch addr/data/op, assert req_valid next clock.
//  - Handshake: req_valid held with stable payload until req_ready; then rsp_ready=1 until rsp_valid.
//    On rsp: latch rsp_data (read) and resp; resp!=0 -> dmistat=2 (sticky). Outstanding cleared same clock.
//  - req_ready and rsp_valid in same clock as req accept: rsp taken that clock.
//  - op 0 (nop) or 3: no request, Capture status only.
//  - dmihardreset with req_valid high: valid drops next clock, late rsp_valid ignored.
// STRUCTURE
//  - jtag_dtm_pkg: tap_state_e (16 states), ir_e codes, dmi_op_e, dmi_stat_e, dmi_req_t, dmi_rsp_t,
//    DTMCS field offsets.
//  - Sub-module jtag_tap_fsm: TAP next-state logic + IR register, advanced by a tck_rise strobe.
//  - Top holds synchronisers, edge detect, DR shift registers, DMI handshake FSM (IDLE/REQ/RSP).
// TESTING
//  - After reset, TLR->Shift-DR, shift 32 -> TDO returns IdcodeValue LSB first (32'h0000_0001).
//  - IR=1F, shift 8'hA5 through DR -> TDO delayed by one TCK (bypass single bit).
//  - IR=11, write {7'h10,32'h1,2'd2} -> one req: addr 10, op 2, data 1; capture status 0.
//  - Read addr 11, rv_dm returns 32'hDEAD_BEEF -> next Capture-DR shifts out data DEADBEEF, status 0.
//  - Hold rsp_valid off, issue 2nd op -> status 3, DTMCS[11:10]=3; dmireset -> 0; new op issued.
//  - rsp_resp=2 -> dmistat=2, later ops dropped; dmihardreset -> dmi_rst_no low 1 clock, dmistat=0.
//  - reset_ni asserted mid-request -> req_valid=0 immediately, IR=IDCODE, TDO_OE=0.

Source files
------------

// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the oversampled JTAG debug transport module.
package jtag_dtm_pkg;

    typedef enum logic [3:0] {
        TAP_TEST_LOGIC_RESET = 4'h0,
        TAP_RUN_TEST_IDLE    = 4'h1,
        TAP_SELECT_DR        = 4'h2,
        TAP_CAPTURE_DR       = 4'h3,
        TAP_SHIFT_DR         = 4'h4,
        TAP_EXIT1_DR         = 4'h5,
        TAP_PAUSE_DR         = 4'h6,
        TAP_EXIT2_DR         = 4'h7,
        TAP_UPDATE_DR        = 4'h8,
        TAP_SELECT_IR        = 4'h9,
        TAP_CAPTURE_IR       = 4'ha,
        TAP_SHIFT_IR         = 4'hb,
        TAP_EXIT1_IR         = 4'hc,
        TAP_PAUSE_IR         = 4'hd,
        TAP_EXIT2_IR         = 4'he,
        TAP_UPDATE_IR        = 4'hf
    } tap_state_e;

    typedef enum logic [4:0] {
        IR_IDCODE = 5'h01,
        IR_DTMCS  = 5'h10,
        IR_DMI    = 5'h11,
        IR_BYPASS = 5'h1f
    } ir_e;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2,
        DMI_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_STAT_OK     = 2'd0,
        DMI_STAT_RSVD   = 2'd1,
        DMI_STAT_FAILED = 2'd2,
        DMI_STAT_BUSY   = 2'd3
    } dmi_stat_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_rsp_t;

    localparam int DTMCS_VERSION_LSB   = 0;
    localparam int DTMCS_ABITS_LSB     = 4;
    localparam int DTMCS_DMISTAT_LSB   = 10;
    localparam int DTMCS_IDLE_LSB      = 12;
    localparam int DTMCS_DMIRESET_BIT  = 16;
    localparam int DTMCS_HARDRESET_BIT = 17;

    // IEEE 1149.1 TAP transition table.
    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        case (state)
            TAP_TEST_LOGIC_RESET: tap_next = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
            TAP_RUN_TEST_IDLE:    tap_next = tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
            TAP_SELECT_DR:        tap_next = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR:       tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:         tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:         tap_next = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:         tap_next = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:         tap_next = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:        tap_next = tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
            TAP_SELECT_IR:        tap_next = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR:       tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:         tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:         tap_next = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:         tap_next = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:         tap_next = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:        tap_next = tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
            default:              tap_next = TAP_TEST_LOGIC_RESET;
        endcase
    endfunction

endpackage

// File: rtl/jtag_dtm_oversampled_tap_fsm.sv
// TAP controller state and instruction register, stepped by TCK edge strobes
// derived from the system-clock oversampled pins.
module jtag_tap_fsm
    import jtag_dtm_pkg::*;
(
    input  logic       clock,
    input  logic       reset_ni,
    input  logic       trst_n,
    input  logic       tck_rise,
    input  logic       tck_fall,
    input  logic       tms,
    input  logic       tdi,
    output tap_state_e state,
    output logic [4:0] ir,
    output logic       ir_tdo
);

    logic [4:0] ir_shift;

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= TAP_TEST_LOGIC_RESET;
            ir       <= IR_IDCODE;
            ir_shift <= 5'b00001;
        end else if (!trst_n) begin
            state <= TAP_TEST_LOGIC_RESET;
            ir    <= IR_IDCODE;
        end else begin
            if (tck_rise) begin
                state <= tap_next(state, tms);
                if (state == TAP_CAPTURE_IR) begin
                    ir_shift <= 5'b00001;
                end else if (state == TAP_SHIFT_IR) begin
                    ir_shift <= {tdi, ir_shift[4:1]};
                end
            end
            // New instruction takes effect on the falling edge inside Update-IR.
            if (tck_fall && state == TAP_UPDATE_IR) begin
                ir <= ir_shift;
            end else if (state == TAP_TEST_LOGIC_RESET) begin
                ir <= IR_IDCODE;
            end
        end
    end

    assign ir_tdo = ir_shift[0];

endmodule

// File: rtl/jtag_dtm_oversampled.sv
// RISC-V debug transport module: JTAG pins oversampled on the system clock,
// DTMCS/DMI data registers and a single-outstanding DMI request handshake.
module jtag_dtm_oversampled
    import jtag_dtm_pkg::*;
#(
    parameter logic [31:0] IdcodeValue = 32'h0000_0001,
    parameter int          AddrWidth   = 7,
    parameter logic [2:0]  IdleCycles  = 3'd1
) (
    input  logic                 clock,
    input  logic                 reset_ni,
    input  logic                 jtag_tck_i,
    input  logic                 jtag_tms_i,
    input  logic                 jtag_tdi_i,
    input  logic                 jtag_trst_ni,
    output logic                 jtag_tdo_o,
    output logic                 jtag_tdo_oe_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]           dmi_req_op_o,
    output logic [31:0]          dmi_req_data_o,
    input  logic                 dmi_rsp_valid_i,
    output logic                 dmi_rsp_ready_o,
    input  logic [31:0]          dmi_rsp_data_i,
    input  logic [1:0]           dmi_rsp_resp_i,
    output logic                 dmi_rst_no
);

    localparam int DmiWidth = AddrWidth + 34;

    localparam logic [1:0] HS_IDLE = 2'd0;
    localparam logic [1:0] HS_REQ  = 2'd1;
    localparam logic [1:0] HS_RSP  = 2'd2;

    logic tck_p0, tck_p1, tck_p2;
    logic tms_p0, tms_p1;
    logic tdi_p0, tdi_p1;
    logic trst_p0, trst_p1;
    logic tck_rise, tck_fall;

    // Stage p0/p1: two-flop synchronisers; p2 keeps the previous TCK for edge detection.
    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            {tck_p0, tck_p1, tck_p2} <= 3'b000;
            {tms_p0, tms_p1}         <= 2'b00;
            {tdi_p0, tdi_p1}         <= 2'b00;
            {trst_p0, trst_p1}       <= 2'b00;
        end else begin
            {tck_p0, tck_p1, tck_p2} <= {jtag_tck_i, tck_p0, tck_p1};
            {tms_p0, tms_p1}         <= {jtag_tms_i, tms_p0};
            {tdi_p0, tdi_p1}         <= {jtag_tdi_i, tdi_p0};
            {trst_p0, trst_p1}       <= {jtag_trst_ni, trst_p0};
        end
    end

    assign tck_rise = tck_p1 & ~tck_p2;
    assign tck_fall = ~tck_p1 & tck_p2;

    tap_state_e tap_state;
    logic [4:0] ir;
    logic       ir_tdo;

    jtag_tap_fsm u_tap (
        .clock    (clock),
        .reset_ni (reset_ni),
        .trst_n   (trst_p1),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms      (tms_p1),
        .tdi      (tdi_p1),
        .state    (tap_state),
        .ir       (ir),
        .ir_tdo   (ir_tdo)
    );

    logic                 capture_dr, shift_dr, update_dr;
    logic [DmiWidth-1:0]  dr_shift;
    logic [31:0]          dtmcs_value;
    logic [1:0]           hs_state;
    logic [1:0]           dmistat;
    logic [1:0]           dmi_status;
    logic                 outstanding;
    logic [AddrWidth-1:0] req_addr;
    dmi_req_t             req_q;
    dmi_rsp_t             rsp_in;
    logic [31:0]          last_rdata;
    logic                 rst_n_q;
    logic                 tdo_q, tdo_oe_q;

    assign capture_dr = tck_rise && tap_state == TAP_CAPTURE_DR;
    assign shift_dr   = tck_rise && tap_state == TAP_SHIFT_DR;
    assign update_dr  = tck_fall && tap_state == TAP_UPDATE_DR;

    assign outstanding = hs_state != HS_IDLE;
    assign dmi_status  = (dmistat != 2'd0) ? dmistat : (outstanding ? DMI_STAT_BUSY : DMI_STAT_OK);

    always_comb begin
        dtmcs_value = '0;
        dtmcs_value[DTMCS_VERSION_LSB +: 4] = 4'd1;
        dtmcs_value[DTMCS_ABITS_LSB +: 6]   = 6'(AddrWidth);
        dtmcs_value[DTMCS_DMISTAT_LSB +: 2] = dmistat;
        dtmcs_value[DTMCS_IDLE_LSB +: 3]    = IdleCycles;
    end

    // Shorter registers shift within their own low bits; the rest of dr_shift is don't-care.
    always_ff @(posedge clock) begin
        if (capture_dr) begin
            case (ir)
                IR_IDCODE: dr_shift <= DmiWidth'(IdcodeValue);
                IR_DTMCS:  dr_shift <= DmiWidth'(dtmcs_value);
                IR_DMI:    dr_shift <= {req_addr, last_rdata, dmi_status};
                default:   dr_shift <= '0;
            endcase
        end else if (shift_dr) begin
            case (ir)
                IR_DMI:              dr_shift <= {tdi_p1, dr_shift[DmiWidth-1:1]};
                IR_IDCODE, IR_DTMCS: dr_shift[31:0] <= {tdi_p1, dr_shift[31:1]};
                default:             dr_shift[0] <= tdi_p1;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else if (tck_fall) begin
            tdo_oe_q <= tap_state == TAP_SHIFT_IR || tap_state == TAP_SHIFT_DR;
            tdo_q    <= (tap_state == TAP_SHIFT_IR) ? ir_tdo :
                        (tap_state == TAP_SHIFT_DR) ? dr_shift[0] : 1'b0;
        end
    end

    logic                 dtmcs_update, dmi_reset, dmi_hard_reset, dmi_update, rsp_take;
    logic [1:0]           dr_op;
    logic [31:0]          dr_data;
    logic [AddrWidth-1:0] dr_addr;

    assign dr_op   = dr_shift[1:0];
    assign dr_data = dr_shift[33:2];
    assign dr_addr = dr_shift[DmiWidth-1 -: AddrWidth];
    assign rsp_in  = '{data: dmi_rsp_data_i, resp: dmi_rsp_resp_i};

    assign dtmcs_update   = update_dr && ir == IR_DTMCS;
    assign dmi_reset      = dtmcs_update && dr_shift[DTMCS_DMIRESET_BIT];
    assign dmi_hard_reset = dtmcs_update && dr_shift[DTMCS_HARDRESET_BIT];
    assign dmi_update     = update_dr && ir == IR_DMI && (dr_op == DMI_READ || dr_op == DMI_WRITE);
    assign rsp_take       = (hs_state == HS_REQ && dmi_req_ready_i && dmi_rsp_valid_i) ||
                            (hs_state == HS_RSP && dmi_rsp_valid_i);

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            hs_state   <= HS_IDLE;
            dmistat    <= DMI_STAT_OK;
            req_addr   <= '0;
            req_q      <= '0;
            last_rdata <= '0;
            rst_n_q    <= 1'b1;
        end else begin
            rst_n_q <= !dmi_hard_reset;
            if (dmi_hard_reset) begin
                hs_state <= HS_IDLE;
                dmistat  <= DMI_STAT_OK;
            end else begin
                if (dmi_reset) begin
                    dmistat <= DMI_STAT_OK;
                end
                case (hs_state)
                    HS_IDLE: if (dmi_update && dmistat == DMI_STAT_OK) begin
                        req_addr <= dr_addr;
                        req_q    <= '{op: dr_op, data: dr_data};
                        hs_state <= HS_REQ;
                    end
                    HS_REQ: if (dmi_req_ready_i) begin
                        hs_state <= dmi_rsp_valid_i ? HS_IDLE : HS_RSP;
                    end
                    HS_RSP: if (dmi_rsp_valid_i) begin
                        hs_state <= HS_IDLE;
                    end
                    default: hs_state <= HS_IDLE;
                endcase
                if (rsp_take && req_q.op == DMI_READ) begin
                    last_rdata <= rsp_in.data;
                end
                // Error sticks until dmireset; busy overrides it because it is raised later.
                if (rsp_take && rsp_in.resp != 2'd0) begin
                    dmistat <= DMI_STAT_FAILED;
                end
                if (dmi_update && outstanding) begin
                    dmistat <= DMI_STAT_BUSY;
                end
            end
        end
    end

    assign jtag_tdo_o      = tdo_q;
    assign jtag_tdo_oe_o   = tdo_oe_q;
    assign dmi_req_valid_o = hs_state == HS_REQ;
    assign dmi_rsp_ready_o = hs_state == HS_RSP;
    assign dmi_req_addr_o  = req_addr;
    assign dmi_req_op_o    = req_q.op;
    assign dmi_req_data_o  = req_q.data;
    assign dmi_rst_no      = rst_n_q;

endmodule

// File: tb/tb_jtag_dtm_oversampled.sv
// Directed bench for jtag_dtm_oversampled: drives JTAG scans slowly against the
// system clock and answers DMI requests with a scripted responder.
module tb_jtag_dtm_oversampled;

    logic        clock = 1'b0;
    logic        reset_ni;
    logic        tck, tms, tdi, trst_ni;
    logic        tdo, tdo_oe;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, dmi_rst_no;
    logic [6:0]  req_addr;
    logic [1:0]  req_op, rsp_resp;
    logic [31:0] req_data, rsp_data;

    int          checks = 0;
    int          failures = 0;
    int          req_count = 0;
    int          rst_low_count = 0;
    logic [6:0]  mon_addr;
    logic [1:0]  mon_op;
    logic [31:0] mon_data;

    always #5 clock = ~clock;

    jtag_dtm_oversampled dut (
        .clock           (clock),
        .reset_ni        (reset_ni),
        .jtag_tck_i      (tck),
        .jtag_tms_i      (tms),
        .jtag_tdi_i      (tdi),
        .jtag_trst_ni    (trst_ni),
        .jtag_tdo_o      (tdo),
        .jtag_tdo_oe_o   (tdo_oe),
        .dmi_req_valid_o (req_valid),
        .dmi_req_ready_i (req_ready),
        .dmi_req_addr_o  (req_addr),
        .dmi_req_op_o    (req_op),
        .dmi_req_data_o  (req_data),
        .dmi_rsp_valid_i (rsp_valid),
        .dmi_rsp_ready_o (rsp_ready),
        .dmi_rsp_data_i  (rsp_data),
        .dmi_rsp_resp_i  (rsp_resp),
        .dmi_rst_no      (dmi_rst_no)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return 64'({a, d, op});
    endfunction

    // One TCK period: TDO/OE are sampled just before the rising edge.
    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic oe_v);
        tms = tms_v;
        tdi = tdi_v;
        wait_clk(4);
        tdo_v = tdo;
        oe_v  = tdo_oe;
        tck = 1'b1;
        wait_clk(4);
        tck = 1'b0;
    endtask

    task automatic scan_ir(input logic [4:0] code, output logic [4:0] cap);
        logic t, o;
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, code[i], t, o);
            cap[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
    endtask

    task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout, output logic oe_all);
        logic t, o;
        dout   = '0;
        oe_all = 1'b1;
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        for (int i = 0; i < len; i++) begin
            tck_cycle(i == len - 1, din[i], t, o);
            dout[i] = t;
            oe_all  = oe_all & o;
        end
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (req_valid && req_ready) begin
                req_count++;
                mon_addr = req_addr;
                mon_op   = req_op;
                mon_data = req_data;
            end
            if (!dmi_rst_no) rst_low_count++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] d;
        logic [4:0]  cap;
        logic        oe, t, o;

        reset_ni = 1'b0; trst_ni = 1'b1;
        tck = 1'b0; tms = 1'b1; tdi = 1'b0;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h0; rsp_resp = 2'd0;
        wait_clk(3);
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_rsp_ready", 64'(rsp_ready), 64'd0);
        check("rst_tdo_oe", 64'(tdo_oe), 64'd0);
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_dmi_rst_no", 64'(dmi_rst_no), 64'd1);
        reset_ni = 1'b1;
        wait_clk(4);

        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        scan_dr(32, 64'h0, d, oe);
        check("idcode", d, 64'h0000_0001);
        check("idcode_oe", 64'(oe), 64'd1);
        wait_clk(4);
        check("idle_oe", 64'(tdo_oe), 64'd0);

        scan_ir(5'h1f, cap);
        check("ir_capture", 64'(cap), 64'h01);
        scan_dr(8, 64'hA5, d, oe);
        check("bypass", d, 64'h4A);

        // TMS held high from Shift-DR returns to Test-Logic-Reset and IDCODE.
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        scan_dr(32, 64'h0, d, oe);
        check("tms5_idcode", d, 64'h0000_0001);

        scan_ir(5'h11, cap);
        rsp_data = 32'h1234_5678;
        scan_dr(41, dmi_word(7'h10, 32'h1, 2'd2), d, oe);
        wait_clk(4);
        check("wr_count", 64'(req_count), 64'd1);
        check("wr_addr", 64'(mon_addr), 64'h10);
        check("wr_op", 64'(mon_op), 64'd2);
        check("wr_data", 64'(mon_data), 64'h1);
        scan_dr(41, dmi_word(7'h0, 32'h0, 2'd0), d, oe);
        check("wr_capture", d, dmi_word(7'h10, 32'h0, 2'd0));

        rsp_data = 32'hDEAD_BEEF;
        scan_dr(41, dmi_word(7'h11, 32'h0, 2'd1), d, oe);
        scan_dr(41, dmi_word(7'h0, 32'h0, 2'd0), d, oe);
        check("rd_capture", d, dmi_word(7'h11, 32'hDEAD_BEEF, 2'd0));
        check("rd_op", 64'(mon_op), 64'd1);

        rsp_valid = 1'b0;
        scan_dr(41, dmi_word(7'h12, 32'hCAFE, 2'd2), d, oe);
        wait_clk(4);
        check("hold_rsp_ready", 64'(rsp_ready), 64'd1);
        scan_dr(41, dmi_word(7'h13, 32'h0, 2'd1), d, oe);
        check("busy_status", 64'(d[1:0]), 64'd3);
        check("busy_dropped", 64'(req_count), 64'd3);
        scan_ir(5'h10, cap);
        scan_dr(32, 64'h0, d, oe);
        check("dtmcs_busy", d, 64'h1C71);
        rsp_valid = 1'b1;
        wait_clk(4);
        scan_dr(32, 64'h1_0000, d, oe);
        scan_dr(32, 64'h0, d, oe);
        check("dtmcs_dmireset", d, 64'h1071);
        scan_ir(5'h11, cap);
        scan_dr(41, dmi_word(7'h14, 32'h5, 2'd2), d, oe);
        wait_clk(4);
        check("after_reset_count", 64'(req_count), 64'd4);
        check("after_reset_addr", 64'(mon_addr), 64'h14);

        rsp_resp = 2'd2;
        scan_dr(41, dmi_word(7'h15, 32'h0, 2'd1), d, oe);
        rsp_resp = 2'd0;
        scan_dr(41, dmi_word(7'h16, 32'h7, 2'd2), d, oe);
        check("failed_status", 64'(d[1:0]), 64'd2);
        scan_dr(41, dmi_word(7'h0, 32'h0, 2'd0), d, oe);
        check("failed_sticky", 64'(d[1:0]), 64'd2);
        check("failed_dropped", 64'(req_count), 64'd5);

        scan_ir(5'h10, cap);
        rst_low_count = 0;
        scan_dr(32, 64'h2_0000, d, oe);
        check("hardreset_pulse", 64'(rst_low_count), 64'd1);
        scan_dr(32, 64'h0, d, oe);
        check("hardreset_dmistat", d, 64'h1071);

        scan_ir(5'h11, cap);
        req_ready = 1'b0;
        scan_dr(41, dmi_word(7'h17, 32'h9, 2'd2), d, oe);
        wait_clk(10);
        check("stall_valid", 64'(req_valid), 64'd1);
        check("stall_addr", 64'(req_addr), 64'h17);
        check("stall_data", 64'(req_data), 64'h9);
        scan_ir(5'h10, cap);
        rst_low_count = 0;
        scan_dr(32, 64'h2_0000, d, oe);
        check("abort_valid", 64'(req_valid), 64'd0);
        check("abort_pulse", 64'(rst_low_count), 64'd1);
        req_ready = 1'b1;
        wait_clk(6);
        check("abort_no_req", 64'(req_count), 64'd5);
        check("abort_rsp_ready", 64'(rsp_ready), 64'd0);

        trst_ni = 1'b0;
        wait_clk(4);
        trst_ni = 1'b1;
        wait_clk(4);
        tck_cycle(1'b0, 1'b0, t, o);
        scan_dr(32, 64'h0, d, oe);
        check("trst_idcode", d, 64'h0000_0001);

        scan_ir(5'h11, cap);
        req_ready = 1'b0;
        scan_dr(41, dmi_word(7'h18, 32'hA, 2'd1), d, oe);
        tck_cycle(1'b1, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        tck_cycle(1'b0, 1'b0, t, o);
        wait_clk(4);
        check("pre_reset_valid", 64'(req_valid), 64'd1);
        check("pre_reset_oe", 64'(tdo_oe), 64'd1);
        reset_ni = 1'b0;
        #1;
        check("async_valid", 64'(req_valid), 64'd0);
        check("async_oe", 64'(tdo_oe), 64'd0);
        check("async_rst_no", 64'(dmi_rst_no), 64'd1);
        wait_clk(2);
        reset_ni = 1'b1;
        req_ready = 1'b1;
        wait_clk(4);
        tck_cycle(1'b0, 1'b0, t, o);
        scan_dr(32, 64'h0, d, oe);
        check("post_reset_idcode", d, 64'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
